tetris_grid_scanout: RTL and testbench
======================================

TETRIS_GRID_SCANOUT -- requirements
Module: tetris_grid_scanout

Interface
REQ-001 SHALL have parameter FIRST_ROW, default 0: first grid row streamed.
REQ-002 SHALL have parameter LAST_ROW, default 20: last grid row streamed; the default excludes floor row 21.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port grid, input, [21:0][9:0][2:0]: game playfield from the game FSM, indexed [row][col], 3-bit color code per cell.
REQ-006 SHALL have port start, input, 1: request one frame scan.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of the current scan.
REQ-008 SHALL have port pix_ready, input, 1: downstream accepts the current pixel.
REQ-009 SHALL have port pix_valid, output, 1: pixel outputs are valid.
REQ-010 SHALL have port pix_code, output, 3: raw cell color code.
REQ-011 SHALL have port pix_rgb, output, 12: palette-mapped color, 4:4:4.
REQ-012 SHALL have port pix_row, output, 5: row of the current pixel.
REQ-013 SHALL have port pix_col, output, 4: column of the current pixel.
REQ-014 SHALL have port sof, output, 1: current pixel is the first of the frame.
REQ-015 SHALL have port eol, output, 1: current pixel is col 9.
REQ-016 SHALL have port eof, output, 1: current pixel is the last of the frame.
REQ-017 SHALL have port busy, output, 1: high when state is not IDLE.
REQ-018 SHALL have port frame_done, output, 1: one-cycle pulse after the final transfer.

Function
REQ-019 SHALL implement states IDLE, STREAM and DONE.
REQ-020 In IDLE with start=1 at an edge, SHALL on that edge:
- copy all of grid into an internal snapshot;
- set row=FIRST_ROW, col=0;
- go to STREAM.
REQ-021 Later changes to grid SHALL NOT affect the frame in progress (no tearing).
REQ-022 start SHALL be ignored outside IDLE; no queuing.
REQ-023 In STREAM, pix_valid SHALL be 1, and pix_code SHALL equal snapshot[row][col].
REQ-024 In STREAM, pix_row and pix_col SHALL equal the row/col counters.
REQ-025 All pixel outputs SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-026 A transfer SHALL occur on an edge with pix_valid=1 and pix_ready=1; at most one pixel per cycle.
REQ-027 On a transfer:
- col<9: col increments;
- col=9: col=0 and row increments;
- row=LAST_ROW and col=9: go to DONE.
REQ-028 sof SHALL be 1 iff row=FIRST_ROW and col=0 in STREAM.
REQ-029 eol SHALL be 1 iff col=9 in STREAM.
REQ-030 eof SHALL be 1 iff row=LAST_ROW and col=9 in STREAM.
REQ-031 DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE.
REQ-032 A start in DONE SHALL be ignored.
REQ-033 abort=1 in STREAM or DONE SHALL go to IDLE at the next edge, with no frame_done and no further pix_valid.
REQ-034 If abort and start are both 1 in IDLE, abort SHALL take priority: no scan starts.
REQ-035 Palette (pix_rgb from pix_code) SHALL be:
- 0 -> 000
- 1 -> F00
- 2 -> 0F0
- 3 -> 00F
- 4 -> FF0
- 5 -> F0F
- 6 -> 0FF
- 7 -> FFF
REQ-036 pix_rgb SHALL be combinational from pix_code; no added latency.
REQ-037 Latency: start sampled at edge N SHALL give pix_valid=1 in the cycle after edge N.
REQ-038 A frame SHALL have exactly (LAST_ROW-FIRST_ROW+1)*10 transfers; 210 with default parameters.
REQ-039 FIRST_ROW<=LAST_ROW<=21 is required; FIRST_ROW=LAST_ROW SHALL stream 10 pixels.
REQ-040 In IDLE and DONE, pix_valid, sof, eol and eof SHALL be 0; pix_code, pix_rgb, pix_row and pix_col SHALL be 0.

Reset
REQ-041 rst=1 SHALL immediately set state=IDLE, regardless of clk.
REQ-042 rst=1 SHALL immediately clear the snapshot and the row/col counters to 0.
REQ-043 rst=1 SHALL immediately force all outputs to 0.
REQ-044 rst asserted mid-frame SHALL abandon the frame with no frame_done.
REQ-045 After rst deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-046 Checkerboard grid (cell=(r+c)%8), pix_ready=1, pulse start -> 210 consecutive beats, r0..r20 row-major, pix_code=(r+c)%8 with matching palette rgb; sof on beat 1, eol every 10th beat, eof on beat 210; frame_done 1 cycle later; busy low after.
REQ-047 Start a scan, then overwrite grid with all 7s at beat 5 -> all 210 beats still match the original snapshot.
REQ-048 Random pix_ready at 30% -> no beat lost or duplicated; outputs held stable across every stall.
REQ-049 abort at beat 100 -> pix_valid=0 next cycle, no frame_done; a new start then streams a full 210 beats from sof.
REQ-050 rst mid-frame -> outputs 0 at once, state IDLE; start while busy -> ignored; FIRST_ROW=LAST_ROW=21 with floor row all 7s -> exactly 10 beats, rgb=FFF.

Source files
------------

// File: rtl/tetris_grid_scanout.sv
// Streams a snapshot of the Tetris playfield one cell per handshake, row-major,
// with frame/line markers and a fixed 8-entry 4:4:4 colour palette.
module tetris_grid_scanout #(
  parameter int FIRST_ROW = 0,
  parameter int LAST_ROW  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [21:0][9:0][2:0] grid,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pix_ready,
  output logic                  pix_valid,
  output logic [2:0]            pix_code,
  output logic [11:0]           pix_rgb,
  output logic [4:0]            pix_row,
  output logic [3:0]            pix_col,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [4:0] FIRST_R = 5'(FIRST_ROW);
  localparam logic [4:0] LAST_R  = 5'(LAST_ROW);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state_q, state_d;
  logic [21:0][9:0][2:0] snap_q, snap_d;
  logic [4:0]            row_q, row_d;
  logic [3:0]            col_q, col_d;

  // Abort wins over everything, including a start seen in IDLE.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          snap_d  = grid;
          row_d   = FIRST_R;
          col_d   = 4'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pix_ready) begin
          if (col_q == 4'd9) begin
            col_d = 4'd0;
            if (row_q == LAST_R) begin
              state_d = DONE;
            end else begin
              row_d = row_q + 5'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Outputs decode directly from state, so reset zeroes them without a clock.
  always_comb begin
    pix_valid  = 1'b0;
    pix_code   = 3'd0;
    pix_row    = 5'd0;
    pix_col    = 4'd0;
    sof        = 1'b0;
    eol        = 1'b0;
    eof        = 1'b0;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    if (state_q == STREAM) begin
      pix_valid = 1'b1;
      pix_code  = snap_q[row_q][col_q];
      pix_row   = row_q;
      pix_col   = col_q;
      sof       = (row_q == FIRST_R) && (col_q == 4'd0);
      eol       = (col_q == 4'd9);
      eof       = (row_q == LAST_R) && (col_q == 4'd9);
    end
  end

  always_comb begin
    pix_rgb = 12'h000;
    case (pix_code)
      3'd0: pix_rgb = 12'h000;
      3'd1: pix_rgb = 12'hF00;
      3'd2: pix_rgb = 12'h0F0;
      3'd3: pix_rgb = 12'h00F;
      3'd4: pix_rgb = 12'hFF0;
      3'd5: pix_rgb = 12'hF0F;
      3'd6: pix_rgb = 12'h0FF;
      3'd7: pix_rgb = 12'hFFF;
      default: pix_rgb = 12'h000;
    endcase
  end

endmodule

// File: tb/tb_tetris_grid_scanout.sv
// Scoreboard bench: expected pixels are generated from the grid snapshot at
// start time and popped by a monitor on every handshake.
module tb_tetris_grid_scanout;

  typedef struct packed {
    logic [2:0]  code;
    logic [11:0] rgb;
    logic [4:0]  row;
    logic [3:0]  col;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  localparam logic [11:0] PAL [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                                      12'hFF0, 12'hF0F, 12'h0FF, 12'hFFF};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [21:0][9:0][2:0] grid = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pix_ready = 1'b1;
  logic pix_valid, sof, eol, eof, busy, frame_done;
  logic [2:0] pix_code;
  logic [11:0] pix_rgb;
  logic [4:0] pix_row;
  logic [3:0] pix_col;

  logic start2 = 1'b0;
  logic pix_valid2, sof2, eol2, eof2, busy2, frame_done2;
  logic [2:0] pix_code2;
  logic [11:0] pix_rgb2;
  logic [4:0] pix_row2;
  logic [3:0] pix_col2;

  int checks = 0;
  int errors = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  bit rand_mode = 1'b0;
  pix_t exp_q[$];

  tetris_grid_scanout dut (
    .clk(clk), .rst(rst), .grid(grid), .start(start), .abort(abort),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_code(pix_code),
    .pix_rgb(pix_rgb), .pix_row(pix_row), .pix_col(pix_col), .sof(sof),
    .eol(eol), .eof(eof), .busy(busy), .frame_done(frame_done)
  );

  tetris_grid_scanout #(.FIRST_ROW(21), .LAST_ROW(21)) dut_floor (
    .clk(clk), .rst(rst), .grid(grid), .start(start2), .abort(1'b0),
    .pix_ready(1'b1), .pix_valid(pix_valid2), .pix_code(pix_code2),
    .pix_rgb(pix_rgb2), .pix_row(pix_row2), .pix_col(pix_col2), .sof(sof2),
    .eol(eol2), .eof(eof2), .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    pix_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame: every cell from first to last row, row-major, from the grid as sampled.
  task automatic push_frame(input int first, input int last);
    pix_t e;
    for (int r = first; r <= last; r++) begin
      for (int c = 0; c < 10; c++) begin
        e.code = grid[r][c];
        e.rgb  = PAL[e.code];
        e.row  = 5'(r);
        e.col  = 4'(c);
        e.sof  = (r == first) && (c == 0);
        e.eol  = (c == 9);
        e.eof  = (r == last) && (c == 9);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: stall stability plus scoreboard pop on every handshake.
  pix_t held;
  bit   holding = 1'b0;
  always @(negedge clk) begin
    pix_t cur, e;
    cur = {pix_code, pix_rgb, pix_row, pix_col, sof, eol, eof};
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (frame_done) done_cnt++;
      if (holding) check("stall_hold", {pix_valid, cur}, {1'b1, held});
      holding = 1'b0;
      if (pix_valid) begin
        if (!pix_ready) begin
          holding = 1'b1;
          held = cur;
        end else begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(cur), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
        end
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1;
    start = 1'b1;
    push_frame(0, 20);
    @(posedge clk); #1;
    start = 1'b0;
    check("latency_valid_sof", {pix_valid, sof}, 2'b11);
  endtask

  task automatic wait_beats(input int target);
    int t;
    for (t = 0; t < 20000 && beat_cnt < target; t++) @(posedge clk);
    if (beat_cnt < target) check("beat_timeout", 64'(beat_cnt), 64'(target));
    #1;
  endtask

  task automatic set_checkerboard();
    for (int r = 0; r < 22; r++)
      for (int c = 0; c < 10; c++)
        grid[r][c] = 3'((r + c) % 8);
  endtask

  task automatic set_random();
    for (int r = 0; r < 22; r++)
      for (int c = 0; c < 10; c++)
        grid[r][c] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int base, dc;
    int n2;

    // Reset state
    #2;
    check("reset_outputs",
          {pix_valid, pix_code, pix_rgb, pix_row, pix_col, sof, eol, eof, busy, frame_done}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, pix_valid}, 2'b00);

    // Checkerboard, full-rate ready, with an ignored start mid-frame
    set_checkerboard();
    base = beat_cnt;
    dc = done_cnt;
    start_frame();
    wait_beats(base + 50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_beats(base + 210);
    check("done_pulse", {frame_done, pix_valid}, 2'b10);
    @(posedge clk); #1;
    check("done_one_cycle", {frame_done, busy}, 2'b00);
    check("frame_len_A", 64'(beat_cnt - base), 64'd210);
    check("queue_empty_A", 64'(exp_q.size()), 64'd0);
    check("done_count_A", 64'(done_cnt - dc), 64'd1);

    // Grid overwritten mid-frame; start during DONE is ignored
    set_random();
    base = beat_cnt;
    dc = done_cnt;
    start_frame();
    wait_beats(base + 5);
    grid = {220{3'd7}};
    wait_beats(base + 210);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", {busy, pix_valid}, 2'b00);
    check("done_count_B", 64'(done_cnt - dc), 64'd1);

    // Random backpressure
    set_random();
    rand_mode = 1'b1;
    base = beat_cnt;
    start_frame();
    wait_beats(base + 210);
    rand_mode = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("frame_len_C", 64'(beat_cnt - base), 64'd210);
    check("queue_empty_C", 64'(exp_q.size()), 64'd0);

    // Abort at beat 100, then a clean restart
    set_checkerboard();
    base = beat_cnt;
    dc = done_cnt;
    start_frame();
    wait_beats(base + 99);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_stops", {pix_valid, busy}, 2'b00);
    check("abort_beats", 64'(beat_cnt - base), 64'd100);
    exp_q.delete();
    repeat (3) @(posedge clk); #1;
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    base = beat_cnt;
    start_frame();
    wait_beats(base + 210);
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort beats start in IDLE
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_over_start", {busy, pix_valid}, 2'b00);

    // Asynchronous reset mid-frame
    base = beat_cnt;
    dc = done_cnt;
    start_frame();
    wait_beats(base + 30);
    #2 rst = 1'b1;
    #1;
    check("rst_immediate",
          {pix_valid, pix_code, pix_rgb, pix_row, pix_col, sof, eol, eof, busy, frame_done}, '0);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("rst_stays_idle", {busy, pix_valid}, 2'b00);
    check("rst_no_done", 64'(done_cnt - dc), 64'd0);

    // Single floor row
    for (int c = 0; c < 10; c++) grid[21][c] = 3'd7;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n2 = 0;
    for (int t = 0; t < 40 && !frame_done2; t++) begin
      @(negedge clk);
      if (pix_valid2) begin
        check("floor_beat",
              {pix_code2, pix_rgb2, pix_row2, pix_col2, sof2, eol2, eof2},
              {3'd7, 12'hFFF, 5'd21, 4'(n2), n2 == 0, n2 == 9, n2 == 9});
        n2++;
      end
    end
    check("floor_count", 64'(n2), 64'd10);
    check("floor_done", 64'(frame_done2), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
